// File: rtl/div_rr_scheduler_pkg.sv
// ============================================================================
//  Module   : div_rr_scheduler_pkg
//  Purpose  : Shared types, default sizes and id-width helper for the
//             round-robin divider scheduler.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package div_rr_scheduler_pkg;

    localparam int c_def_nreq = 4;
    localparam int c_def_w    = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_rr_scheduler_if.sv
// ============================================================================
//  Module   : div_rr_scheduler_if
//  Purpose  : Requester, response and divider signal bundle. The master
//             modport is the scheduler; the slave modport is its environment.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface div_rr_scheduler_if
    import div_rr_scheduler_pkg::*;
#(
    parameter int NREQ = c_def_nreq,
    parameter int W    = c_def_w
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   rsp_valid;
    logic              rsp_ready;
    logic [W-1:0]      rsp_q;
    logic [W-1:0]      rsp_r;
    logic              rsp_err;
    logic              div_start;
    logic [W-1:0]      div_a;
    logic [W-1:0]      div_b;
    logic [W-1:0]      div_q;
    logic [W-1:0]      div_r;
    logic              div_done;
    logic              busy;

    modport master (
        input  req_valid, req_a, req_b, rsp_ready, div_q, div_r, div_done,
        output req_ready, rsp_valid, rsp_q, rsp_r, rsp_err,
               div_start, div_a, div_b, busy
    );

    modport slave (
        output req_valid, req_a, req_b, rsp_ready, div_q, div_r, div_done,
        input  req_ready, rsp_valid, rsp_q, rsp_r, rsp_err,
               div_start, div_a, div_b, busy
    );

endinterface

`default_nettype wire

// File: rtl/div_rr_scheduler_rr_pick.sv
// ============================================================================
//  Module   : rr_pick
//  Purpose  : Combinational round-robin picker: first set request bit found
//             searching from i_ptr upward with wrap.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick
    import div_rr_scheduler_pkg::*;
#(
    parameter int NREQ = c_def_nreq,
    parameter int IDW  = id_width(NREQ)
) (
    input  wire logic [NREQ-1:0] i_req,
    input  wire logic [IDW-1:0]  i_ptr,
    output logic      [NREQ-1:0] o_grant,
    output logic      [IDW-1:0]  o_idx,
    output logic                 o_any
);

    // Scan from the farthest offset down so the nearest hit is written last.
    always_comb begin
        int j;
        j       = 0;
        o_idx   = '0;
        o_any   = 1'b0;
        o_grant = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = (int'(i_ptr) + k) % NREQ;
            if (i_req[j]) begin
                o_idx = IDW'(j);
                o_any = 1'b1;
            end
        end
        if (o_any) begin
            o_grant[o_idx] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/div_rr_scheduler.sv
// ============================================================================
//  Module   : div_rr_scheduler
//  Purpose  : Round-robin sharing of one start/done divider among NREQ
//             requesters. Optional macro DIV_ARB_ZERO_CHECK_EN answers B==0
//             locally without starting the divider.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module div_rr_scheduler
    import div_rr_scheduler_pkg::*;
#(
    parameter int NREQ = c_def_nreq,
    parameter int W    = c_def_w
) (
    input wire logic          clk,
    input wire logic          rst_n,
    div_rr_scheduler_if.master bus
);

    localparam int IDW = id_width(NREQ);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_id;
    logic [W-1:0]     r_div_a;
    logic [W-1:0]     r_div_b;
    logic [W-1:0]     r_rsp_q;
    logic [W-1:0]     r_rsp_r;
    logic [NREQ-1:0]  w_grant;
    logic [IDW-1:0]   w_idx;
    logic             w_any;
    logic [W-1:0]     w_sel_a;
    logic [W-1:0]     w_sel_b;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .i_req   (bus.req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_sel_a = bus.req_a[w_idx*W +: W];
    assign w_sel_b = bus.req_b[w_idx*W +: W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        bus.div_start = 1'b0;
        bus.busy      = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                bus.req_ready = w_grant;
                if (w_any) begin
`ifdef DIV_ARB_ZERO_CHECK_EN
                    w_state_nxt = (w_sel_b == '0) ? RESP : ISSUE;
`else
                    w_state_nxt = ISSUE;
`endif
                end
            end
            ISSUE: begin
                // A done level left over from the previous op is not looked at here.
                bus.div_start = 1'b1;
                w_state_nxt   = WAIT;
            end
            WAIT: begin
                if (bus.div_done) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                bus.rsp_valid[r_id] = 1'b1;
                if (bus.rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

`ifdef DIV_ARB_ZERO_CHECK_EN
    logic r_rsp_err;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_id    <= '0;
            r_div_a <= '0;
            r_div_b <= '0;
            r_rsp_q <= '0;
            r_rsp_r <= '0;
`ifdef DIV_ARB_ZERO_CHECK_EN
            r_rsp_err <= 1'b0;
`endif
        end else begin
            if (r_state == IDLE && w_any) begin
                r_id    <= w_idx;
                r_div_a <= w_sel_a;
                r_div_b <= w_sel_b;
`ifdef DIV_ARB_ZERO_CHECK_EN
                r_rsp_err <= (w_sel_b == '0);
                if (w_sel_b == '0) begin
                    r_rsp_q <= '1;
                    r_rsp_r <= w_sel_a;
                end
`endif
            end
            if (r_state == WAIT && bus.div_done) begin
                r_rsp_q <= bus.div_q;
                r_rsp_r <= bus.div_r;
            end
            if (r_state == RESP && bus.rsp_ready) begin
                r_ptr <= (r_id == IDW'(NREQ - 1)) ? '0 : r_id + 1'b1;
            end
        end
    end

    assign bus.div_a = r_div_a;
    assign bus.div_b = r_div_b;
    assign bus.rsp_q = r_rsp_q;
    assign bus.rsp_r = r_rsp_r;
`ifdef DIV_ARB_ZERO_CHECK_EN
    assign bus.rsp_err = r_rsp_err;
`else
    assign bus.rsp_err = 1'b0;
`endif

endmodule

`default_nettype wire
